// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: arbitration modes,
// port identifiers and the default lock bound.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      MODE_ARB   = 2'd0,
      MODE_LOCK0 = 2'd1,
      MODE_LOCK1 = 2'd2
   } arb_mode_e;

   localparam logic        PORT0            = 1'b0;
   localparam logic        PORT1            = 1'b1;
   localparam int unsigned DEFAULT_MAX_LOCK = 4;

   function automatic arb_mode_e lock_mode(input logic port);
      return (port == PORT1) ? MODE_LOCK1 : MODE_LOCK0;
   endfunction

endpackage

// File: rtl/rr_lock_sel.sv
// Grant decision for two requesters: round-robin between unlocked requests,
// bounded ownership when a port asks to keep the memory for its next access.
module rr_lock_sel
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_LOCK = DEFAULT_MAX_LOCK
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [1:0] req_i,
   input  logic [1:0] lock_i,
   output logic [1:0] gnt_o
);

   localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

   arb_mode_e        mode_q, mode_d;
   logic             prio_q, prio_d;
   logic [LCW-1:0]   cnt_q,  cnt_d;
   logic [1:0]       gnt;
   logic             owner;
   logic             win;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      gnt    = '0;
      mode_d = mode_q;
      prio_d = prio_q;
      cnt_d  = cnt_q;
      win    = PORT0;
      owner  = (mode_q == MODE_LOCK1);

      if (mode_q != MODE_ARB && req_i[owner]) begin
         if (cnt_q == LCW'(MAX_LOCK) && req_i[~owner]) begin
            // Lock budget spent and the other port is waiting: hand over.
            gnt[~owner] = 1'b1;
            prio_d      = owner;
            mode_d      = lock_i[~owner] ? lock_mode(~owner) : MODE_ARB;
            cnt_d       = lock_i[~owner] ? LCW'(1) : '0;
         end else begin
            gnt[owner] = 1'b1;
            if (cnt_q != LCW'(MAX_LOCK)) cnt_d = cnt_q + 1'b1;
            mode_d = lock_i[owner] ? lock_mode(owner) : MODE_ARB;
         end
      end else begin
         // Unlocked, or the owner dropped its request: plain round-robin.
         mode_d = MODE_ARB;
         if (req_i != 2'b00) begin
            win      = (req_i == 2'b11) ? prio_q : req_i[1];
            gnt[win] = 1'b1;
            prio_d   = ~win;
            mode_d   = lock_i[win] ? lock_mode(win) : MODE_ARB;
            cnt_d    = lock_i[win] ? LCW'(1) : '0;
         end
      end
   end

   assign gnt_o = RSTn ? gnt : 2'b00;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         mode_q <= MODE_ARB;
         prio_q <= PORT0;
         cnt_q  <= '0;
      end else begin
         mode_q <= mode_d;
         prio_q <= prio_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data SRAM between the core data port (0) and the
// debug/loader master (1); tracks read returns and counts contention cycles.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned DWIDTH   = 32,
   parameter int unsigned MAX_LOCK = DEFAULT_MAX_LOCK,
   parameter int unsigned CNTW     = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              LOCK0,
   input  logic              LOCK1,
   input  logic              WE0,
   input  logic              WE1,
   input  logic [3:0]        BE0,
   input  logic [3:0]        BE1,
   input  logic [AWIDTH-1:0] ADDR0,
   input  logic [AWIDTH-1:0] ADDR1,
   input  logic [DWIDTH-1:0] WDATA0,
   input  logic [DWIDTH-1:0] WDATA1,
   output logic              GNT0,
   output logic              GNT1,
   output logic              RVALID0,
   output logic              RVALID1,
   output logic [DWIDTH-1:0] RDATA0,
   output logic [DWIDTH-1:0] RDATA1,
   output logic              MEM_CSN,
   output logic              MEM_WEN,
   output logic [3:0]        MEM_BE,
   output logic [AWIDTH-1:0] MEM_ADDR,
   output logic [DWIDTH-1:0] MEM_DI,
   input  logic [DWIDTH-1:0] MEM_DOUT,
   output logic [CNTW-1:0]   CONFLICT_CNT
);

   logic [1:0]      gnt;
   logic            any_gnt;
   logic            win_we;
   logic [1:0]      rd_pend_q;
   logic [CNTW-1:0] conflict_q;

   rr_lock_sel #(.MAX_LOCK(MAX_LOCK)) u_sel (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .req_i  ({REQ1, REQ0}),
      .lock_i ({LOCK1, LOCK0}),
      .gnt_o  (gnt)
   );

   assign GNT0    = gnt[0];
   assign GNT1    = gnt[1];
   assign any_gnt = |gnt;

   // Port 0 is the default mux leg, so an idle bus shows port-0 address/data.
   assign win_we   = gnt[1] ? WE1 : WE0;
   assign MEM_CSN  = ~any_gnt;
   assign MEM_WEN  = ~(any_gnt & win_we);
   assign MEM_BE   = (any_gnt & win_we) ? (gnt[1] ? BE1 : BE0) : 4'b0000;
   assign MEM_ADDR = gnt[1] ? ADDR1  : ADDR0;
   assign MEM_DI   = gnt[1] ? WDATA1 : WDATA0;

   assign RVALID0 = rd_pend_q[0];
   assign RVALID1 = rd_pend_q[1];
   assign RDATA0  = MEM_DOUT;
   assign RDATA1  = MEM_DOUT;

   assign CONFLICT_CNT = conflict_q;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         rd_pend_q  <= 2'b00;
         conflict_q <= '0;
      end else begin
         rd_pend_q <= gnt & ~{WE1, WE0};
         if (REQ0 && REQ1 && conflict_q != {CNTW{1'b1}})
            conflict_q <= conflict_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised and directed bench for dmem_port_arbiter with an SRAM model and
// an owner/run-length reference model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int AW       = 12;
   localparam int DW       = 32;
   localparam int MAX_LOCK = 4;
   localparam int CNTW     = 6;
   localparam int CONF_MAX = (1 << CNTW) - 1;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic [1:0]    req = '0, lck = '0, we = '0;
   logic [3:0]    be    [2];
   logic [AW-1:0] addr  [2];
   logic [DW-1:0] wdata [2];

   logic            GNT0, GNT1, RVALID0, RVALID1, MEM_CSN, MEM_WEN;
   logic [DW-1:0]   RDATA0, RDATA1, MEM_DI;
   logic [DW-1:0]   MEM_DOUT = '0;
   logic [3:0]      MEM_BE;
   logic [AW-1:0]   MEM_ADDR;
   logic [CNTW-1:0] CONFLICT_CNT;

   dmem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_LOCK(MAX_LOCK), .CNTW(CNTW)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .REQ0(req[0]), .REQ1(req[1]), .LOCK0(lck[0]), .LOCK1(lck[1]),
      .WE0(we[0]), .WE1(we[1]), .BE0(be[0]), .BE1(be[1]),
      .ADDR0(addr[0]), .ADDR1(addr[1]), .WDATA0(wdata[0]), .WDATA1(wdata[1]),
      .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
      .RDATA0(RDATA0), .RDATA1(RDATA1),
      .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
      .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT), .CONFLICT_CNT(CONFLICT_CNT)
   );

   always #5 CLK = ~CLK;

   // Synchronous-read SRAM with byte enables.
   logic [DW-1:0] sram [1 << AW];
   always @(posedge CLK) begin
      if (!MEM_CSN) begin
         if (!MEM_WEN) begin
            for (int b = 0; b < 4; b++)
               if (MEM_BE[b]) sram[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
         end else begin
            MEM_DOUT <= sram[MEM_ADDR];
         end
      end
   end

   // Reference model: who owns the memory, how long it has held it, who is
   // favoured next, plus a shadow of memory contents and expected responses.
   int            m_owner, m_run, m_prio, m_conf;
   logic [DW-1:0] shadow [1 << AW];
   logic          exp_rv [2];
   logic [DW-1:0] exp_rd [2];
   logic          granted [2];

   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
   endtask

   task automatic model_reset();
      m_owner = -1; m_run = 0; m_prio = 0; m_conf = 0;
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      granted[0] = 1'b0; granted[1] = 1'b0;
   endtask

   // Sample on the falling edge, compare, then advance the model one cycle.
   task automatic at_neg();
      int w, o;
      logic          w_we;
      logic [3:0]    w_be;
      logic [AW-1:0] w_ad;
      logic [DW-1:0] w_wd;
      @(negedge CLK);
      check("rvalid0", RVALID0, exp_rv[0]);
      check("rvalid1", RVALID1, exp_rv[1]);
      if (exp_rv[0]) check("rdata0", RDATA0, exp_rd[0]);
      if (exp_rv[1]) check("rdata1", RDATA1, exp_rd[1]);
      check("conflict_cnt", CONFLICT_CNT, m_conf);
      granted[0] = 1'b0; granted[1] = 1'b0;
      if (!RSTn) begin
         check("rst_gnt0", GNT0, 0);
         check("rst_gnt1", GNT1, 0);
         check("rst_csn", MEM_CSN, 1);
         check("rst_wen", MEM_WEN, 1);
         check("rst_be", MEM_BE, 0);
         model_reset();
      end else begin
         w = -1;
         if (m_owner >= 0 && req[m_owner]) begin
            o = 1 - m_owner;
            if (m_run >= MAX_LOCK && req[o]) begin
               w = o;
               m_prio  = m_owner;
               m_owner = lck[o] ? o : -1;
               m_run   = lck[o] ? 1 : 0;
            end else begin
               w = m_owner;
               m_run = (m_run + 1 > MAX_LOCK) ? MAX_LOCK : m_run + 1;
               if (!lck[w]) m_owner = -1;
            end
         end else begin
            m_owner = -1;
            if (req[0] && req[1]) w = m_prio;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
            if (w >= 0) begin
               m_prio = 1 - w;
               if (lck[w]) begin m_owner = w; m_run = 1; end
            end
         end
         check("gnt0", GNT0, w == 0);
         check("gnt1", GNT1, w == 1);
         check("mem_csn", MEM_CSN, w < 0);
         exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
         if (w >= 0) begin
            w_we = we[w]; w_be = be[w]; w_ad = addr[w]; w_wd = wdata[w];
            granted[w] = 1'b1;
            check("mem_wen", MEM_WEN, !w_we);
            check("mem_be", MEM_BE, w_we ? w_be : 4'b0000);
            check("mem_addr", MEM_ADDR, w_ad);
            if (w_we) begin
               check("mem_di", MEM_DI, w_wd);
               for (int b = 0; b < 4; b++)
                  if (w_be[b]) shadow[w_ad][8*b +: 8] = w_wd[8*b +: 8];
            end else begin
               exp_rv[w] = 1'b1;
               exp_rd[w] = shadow[w_ad];
            end
         end else begin
            check("idle_wen", MEM_WEN, 1);
            check("idle_be", MEM_BE, 0);
         end
         if (req[0] && req[1] && m_conf < CONF_MAX) m_conf++;
      end
   endtask

   task automatic to_pos();
      @(posedge CLK);
      #1;
   endtask

   task automatic tick();
      at_neg();
      to_pos();
   endtask

   task automatic set_port(input int p, input logic r, input logic l, input logic w,
                           input logic [3:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[p] = r; lck[p] = l; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
   endtask

   task automatic rand_drive();
      for (int p = 0; p < 2; p++) begin
         if (!req[p] || granted[p])
            set_port(p, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40,
                     $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                     AW'($urandom_range(0, 15)), DW'($urandom));
      end
   endtask

   int alt_exp;
   int lock_pat [6] = '{1, 1, 1, 1, 0, 1};

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin sram[i] = '0; shadow[i] = '0; end
      for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 4'h0, '0, '0);
      model_reset();

      // Reset with no requests.
      repeat (2) @(posedge CLK);
      #1;
      tick();
      check("rst_rvalid0", RVALID0, 0);
      check("rst_conf", CONFLICT_CNT, 0);
      RSTn = 1'b1;
      tick();

      // Full-word write then read back on port 0.
      set_port(0, 1, 0, 1, 4'hF, 12'h010, 32'h0000_02dd);
      at_neg(); check("wr_gnt0", GNT0, 1); check("wr_wen", MEM_WEN, 0); to_pos();
      we[0] = 1'b0;
      at_neg(); check("rd_gnt0", GNT0, 1); check("rd_wen", MEM_WEN, 1); to_pos();
      req[0] = 1'b0;
      at_neg(); check("rd_rvalid0", RVALID0, 1); check("rd_data0", RDATA0, 32'h0000_02dd); to_pos();

      // Byte write merges into existing word.
      set_port(0, 1, 0, 1, 4'b0001, 12'h010, 32'h0000_00cc);
      tick();
      we[0] = 1'b0;
      tick();
      req[0] = 1'b0;
      at_neg(); check("bw_data0", RDATA0, 32'h0000_02cc); to_pos();

      // Both ports unlocked: strict alternation, port 1 first after port-0 grants.
      set_port(0, 1, 0, 0, 4'h0, 12'h010, '0);
      set_port(1, 1, 0, 0, 4'h0, 12'h020, '0);
      alt_exp = 1;
      for (int i = 0; i < 6; i++) begin
         at_neg(); check("alt_gnt1", GNT1, alt_exp == 1); to_pos();
         alt_exp = 1 - alt_exp;
      end

      // Port 1 locks: four grants, forced hand-off to port 0, then relock.
      lck[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         at_neg(); check("lock_gnt1", GNT1, lock_pat[i] == 1); to_pos();
      end

      // Reset lands on the edge that would have launched a port-1 read.
      set_port(0, 0, 0, 0, 4'h0, '0, '0);
      set_port(1, 1, 0, 0, 4'h0, 12'h010, '0);
      at_neg(); check("mr_gnt1", GNT1, 1);
      RSTn = 1'b0;
      model_reset();
      to_pos();
      at_neg(); check("mr_rvalid1", RVALID1, 0); to_pos();
      RSTn = 1'b1;
      req[0] = 1'b1;
      at_neg(); check("mr_gnt0", GNT0, 1); to_pos();

      // Random traffic, both ports, random locks, small address window.
      for (int i = 0; i < 3000; i++) begin
         rand_drive();
         tick();
      end
      at_neg();
      check("conf_saturated", CONFLICT_CNT, CONF_MAX);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
